// File: rtl/jesd204_8b10b_decoder.sv
// 8b/10b receive decoder: per-symbol code-group lookup in stage 1, running
// disparity chained across the word in stage 2. Two-clock latency, no handshake.
module jesd204_8b10b_decoder #(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_PATH_WIDTH*10-1:0] in_data,
    output logic [DATA_PATH_WIDTH*8-1:0]  out_data,
    output logic [DATA_PATH_WIDTH-1:0]    out_charisk,
    output logic [DATA_PATH_WIDTH-1:0]    out_notintable,
    output logic [DATA_PATH_WIDTH-1:0]    out_disperr,
    output logic                          out_running_disparity
);
    localparam int DW = DATA_PATH_WIDTH;

    // 6b code in abcdei order (a = MSB of the literal) -> {valid, EDCBA}
    function automatic logic [5:0] lookup_6b(input logic [5:0] c);
        logic [5:0] r;
        case (c)
            6'b100111, 6'b011000: r = {1'b1, 5'd0};
            6'b011101, 6'b100010: r = {1'b1, 5'd1};
            6'b101101, 6'b010010: r = {1'b1, 5'd2};
            6'b110001:            r = {1'b1, 5'd3};
            6'b110101, 6'b001010: r = {1'b1, 5'd4};
            6'b101001:            r = {1'b1, 5'd5};
            6'b011001:            r = {1'b1, 5'd6};
            6'b111000, 6'b000111: r = {1'b1, 5'd7};
            6'b111001, 6'b000110: r = {1'b1, 5'd8};
            6'b100101:            r = {1'b1, 5'd9};
            6'b010101:            r = {1'b1, 5'd10};
            6'b110100:            r = {1'b1, 5'd11};
            6'b001101:            r = {1'b1, 5'd12};
            6'b101100:            r = {1'b1, 5'd13};
            6'b011100:            r = {1'b1, 5'd14};
            6'b010111, 6'b101000: r = {1'b1, 5'd15};
            6'b011011, 6'b100100: r = {1'b1, 5'd16};
            6'b100011:            r = {1'b1, 5'd17};
            6'b010011:            r = {1'b1, 5'd18};
            6'b110010:            r = {1'b1, 5'd19};
            6'b001011:            r = {1'b1, 5'd20};
            6'b101010:            r = {1'b1, 5'd21};
            6'b011010:            r = {1'b1, 5'd22};
            6'b111010, 6'b000101: r = {1'b1, 5'd23};
            6'b110011, 6'b001100: r = {1'b1, 5'd24};
            6'b100110:            r = {1'b1, 5'd25};
            6'b010110:            r = {1'b1, 5'd26};
            6'b110110, 6'b001001: r = {1'b1, 5'd27};
            6'b001110, 6'b001111,
            6'b110000:            r = {1'b1, 5'd28};
            6'b101110, 6'b010001: r = {1'b1, 5'd29};
            6'b011110, 6'b100001: r = {1'b1, 5'd30};
            6'b101011, 6'b010100: r = {1'b1, 5'd31};
            default:              r = 6'd0;
        endcase
        return r;
    endfunction

    // 4b code in fghj order (f = MSB of the literal) -> {valid, HGF}
    function automatic logic [3:0] lookup_4b(input logic [3:0] c);
        logic [3:0] r;
        case (c)
            4'b1011, 4'b0100:                   r = {1'b1, 3'd0};
            4'b1001:                            r = {1'b1, 3'd1};
            4'b0101:                            r = {1'b1, 3'd2};
            4'b1100, 4'b0011:                   r = {1'b1, 3'd3};
            4'b1101, 4'b0010:                   r = {1'b1, 3'd4};
            4'b1010:                            r = {1'b1, 3'd5};
            4'b0110:                            r = {1'b1, 3'd6};
            4'b1110, 4'b0001, 4'b0111, 4'b1000: r = {1'b1, 3'd7};
            default:                            r = 4'd0;
        endcase
        return r;
    endfunction

    // Disparity descriptor {constrained, required RD, RD after}
    function automatic logic [2:0] disp_6b(input logic [5:0] c);
        logic pos, neg, sp_p, sp_m;
        pos  = ($countones(c) == 4);
        neg  = ($countones(c) == 2);
        sp_p = (c == 6'b000111);
        sp_m = (c == 6'b111000);
        return {pos | neg | sp_p | sp_m, neg | sp_p, pos | sp_p};
    endfunction

    function automatic logic [2:0] disp_4b(input logic [3:0] c);
        logic pos, neg, sp_p, sp_m;
        pos  = ($countones(c) == 3);
        neg  = ($countones(c) == 1);
        sp_p = (c == 4'b0011);
        sp_m = (c == 4'b1100);
        return {pos | neg | sp_p | sp_m, neg | sp_p, pos | sp_p};
    endfunction

    logic [DW*8-1:0] data_next;
    logic [DW-1:0]   charisk_next;
    logic [DW-1:0]   nit_next;
    logic [DW*3-1:0] d6_next;
    logic [DW*3-1:0] d4_next;

    for (genvar gi = 0; gi < DW; gi++) begin : g_sym
        logic [5:0] c6;
        logic [3:0] c4;
        logic [3:0] c4_eff;
        logic [5:0] l6;
        logic [3:0] l4;
        logic [4:0] x;
        logic       k28, a7, p7, set_m, set_p, set_k;
        logic       bad_k, bad_a7, bad_p7, nit;

        assign c6 = {in_data[10*gi+0], in_data[10*gi+1], in_data[10*gi+2],
                     in_data[10*gi+3], in_data[10*gi+4], in_data[10*gi+5]};
        assign c4 = {in_data[10*gi+6], in_data[10*gi+7], in_data[10*gi+8], in_data[10*gi+9]};

        assign k28 = (c6 == 6'b001111) || (c6 == 6'b110000);
        // Balanced K28.y trailers are inverted after the RD+ form of K28
        assign c4_eff = ((c6 == 6'b110000) &&
                         ((c4 == 4'b1001) || (c4 == 4'b0110) ||
                          (c4 == 4'b0101) || (c4 == 4'b1010))) ? ~c4 : c4;

        assign l6 = lookup_6b(c6);
        assign l4 = lookup_4b(c4_eff);
        assign x  = l6[4:0];

        assign a7    = (c4 == 4'b0111) || (c4 == 4'b1000);
        assign p7    = (c4 == 4'b1110) || (c4 == 4'b0001);
        assign set_m = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
        assign set_p = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
        assign set_k = (x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30);

        assign bad_k  = k28 & p7;
        assign bad_a7 = a7 & ~k28 & ~set_k &
                        ~(((c4 == 4'b0111) & set_m) | ((c4 == 4'b1000) & set_p));
        assign bad_p7 = ((c4 == 4'b1110) & set_m) | ((c4 == 4'b0001) & set_p);
        assign nit    = ~l6[5] | ~l4[3] | bad_k | bad_a7 | bad_p7;

        assign data_next[8*gi +: 8] = {l4[2:0], x};
        assign charisk_next[gi]     = ~nit & (k28 | (a7 & set_k));
        assign nit_next[gi]         = nit;
        assign d6_next[3*gi +: 3]   = disp_6b(c6);
        assign d4_next[3*gi +: 3]   = disp_4b(c4);
    end

    logic [DW*8-1:0] s1_data_reg;
    logic [DW-1:0]   s1_charisk_reg;
    logic [DW-1:0]   s1_nit_reg;
    logic [DW*3-1:0] s1_d6_reg;
    logic [DW*3-1:0] s1_d4_reg;

    logic [DW*8-1:0] data_reg;
    logic [DW-1:0]   charisk_reg;
    logic [DW-1:0]   nit_reg;
    logic [DW-1:0]   disperr_reg;
    logic            rd_reg;

    logic [DW-1:0]   disperr_next;
    logic            rd_next;
    logic            rd_chain;

    // Every received sub-block with a disparity bias forces RD, so one error
    // does not cascade into the following symbols.
    always_comb begin
        rd_chain     = rd_reg;
        disperr_next = '0;
        for (int k = 0; k < DW; k++) begin
            if (s1_d6_reg[3*k+2]) begin
                disperr_next[k] = (rd_chain != s1_d6_reg[3*k+1]);
                rd_chain        = s1_d6_reg[3*k];
            end
            if (s1_d4_reg[3*k+2]) begin
                if (rd_chain != s1_d4_reg[3*k+1]) disperr_next[k] = 1'b1;
                rd_chain = s1_d4_reg[3*k];
            end
        end
        rd_next = rd_chain;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_data_reg    <= '0;
            s1_charisk_reg <= '0;
            s1_nit_reg     <= '0;
            s1_d6_reg      <= '0;
            s1_d4_reg      <= '0;
            data_reg       <= '0;
            charisk_reg    <= '0;
            nit_reg        <= '0;
            disperr_reg    <= '0;
            rd_reg         <= 1'b0;
        end else begin
            s1_data_reg    <= data_next;
            s1_charisk_reg <= charisk_next;
            s1_nit_reg     <= nit_next;
            s1_d6_reg      <= d6_next;
            s1_d4_reg      <= d4_next;
            data_reg       <= s1_data_reg;
            charisk_reg    <= s1_charisk_reg;
            nit_reg        <= s1_nit_reg;
            disperr_reg    <= disperr_next;
            rd_reg         <= rd_next;
        end
    end

    assign out_data              = data_reg;
    assign out_charisk           = charisk_reg;
    assign out_notintable        = nit_reg;
    assign out_disperr           = disperr_reg;
    assign out_running_disparity = rd_reg;

endmodule

// File: tb/tb_jesd204_8b10b_decoder.sv
// Bench for jesd204_8b10b_decoder: vector table of hand-derived words fed
// through a latency-tagged scoreboard, plus an asynchronous reset sequence.
module tb_jesd204_8b10b_decoder;
    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] in_data;
    logic [31:0] out_data;
    logic [3:0]  out_charisk;
    logic [3:0]  out_notintable;
    logic [3:0]  out_disperr;
    logic        out_running_disparity;

    jesd204_8b10b_decoder #(.DATA_PATH_WIDTH(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .in_data               (in_data),
        .out_data              (out_data),
        .out_charisk           (out_charisk),
        .out_notintable        (out_notintable),
        .out_disperr           (out_disperr),
        .out_running_disparity (out_running_disparity)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [39:0] din;
        logic [31:0] data;
        logic [3:0]  k;
        logic [3:0]  nit;
        logic [3:0]  de;
        logic        rd;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
        logic [3:0]  k;
        logic [3:0]  nit;
        logic [3:0]  de;
        logic        rd;
    } exp_t;

    exp_t sb[$];
    vec_t vecs [16];
    int tests  = 0;
    int failed = 0;

    function automatic logic [39:0] w4(input logic [9:0] s0, input logic [9:0] s1,
                                       input logic [9:0] s2, input logic [9:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic push(input int due, input int id, input logic [31:0] d,
                        input logic [3:0] k, input logic [3:0] nit,
                        input logic [3:0] de, input logic rd);
        exp_t e;
        e.due = due; e.id = id; e.data = d; e.k = k; e.nit = nit; e.de = de; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic check_due();
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (e.due != cyc ||
                {out_data, out_charisk, out_notintable, out_disperr, out_running_disparity} !==
                {e.data, e.k, e.nit, e.de, e.rd}) begin
                failed++;
                $display("[TB] FAIL word%0d cyc=%0d got data=%h k=%h nit=%h de=%h rd=%b exp data=%h k=%h nit=%h de=%h rd=%b",
                         e.id, cyc, out_data, out_charisk, out_notintable, out_disperr,
                         out_running_disparity, e.data, e.k, e.nit, e.de, e.rd);
            end else begin
                $display("[TB] ok   word%0d data=%h k=%h nit=%h de=%h rd=%b",
                         e.id, out_data, out_charisk, out_notintable, out_disperr,
                         out_running_disparity);
            end
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({out_data, out_charisk, out_notintable, out_disperr, out_running_disparity} !== 45'd0) begin
            failed++;
            $display("[TB] FAIL %s got data=%h k=%h nit=%h de=%h rd=%b exp all zero",
                     name, out_data, out_charisk, out_notintable, out_disperr, out_running_disparity);
        end else begin
            $display("[TB] ok   %s all outputs zero", name);
        end
    endtask

    task automatic step(input vec_t v, input int id);
        @(posedge clk);
        #2;
        in_data = v.din;
        push(cyc + 2, id, v.data, v.k, v.nit, v.de, v.rd);
        @(negedge clk);
        check_due();
    endtask

    initial begin
        // Continuous RD chain; each row's expectation starts from the previous row's RD
        vecs[0]  = '{w4(10'h17C, 10'h283, 10'h17C, 10'h283), 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{w4(10'h17C, 10'h283, 10'h17C, 10'h283), 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0, 1'b0};
        vecs[2]  = '{w4(10'h155, 10'h155, 10'h155, 10'h155), 32'hB5B5B5B5, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[3]  = '{w4(10'h155, 10'h155, 10'h155, 10'h155), 32'hB5B5B5B5, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[4]  = '{w4(10'h17C, 10'h17C, 10'h283, 10'h17C), 32'hBCBCBCBC, 4'hF, 4'h0, 4'h2, 1'b1};
        vecs[5]  = '{w4(10'h283, 10'h17C, 10'h283, 10'h17C), 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0, 1'b1};
        vecs[6]  = '{w4(10'h155, 10'h155, 10'h155, 10'h155), 32'hB5B5B5B5, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[7]  = '{w4(10'h283, 10'h17C, 10'h283, 10'h155), 32'hB5BCBCBC, 4'h7, 4'h0, 4'h0, 1'b0};
        vecs[8]  = '{w4(10'h17C, 10'h283, 10'h000, 10'h17C), 32'hBC00BCBC, 4'hB, 4'h4, 4'h0, 1'b1};
        vecs[9]  = '{w4(10'h283, 10'h17C, 10'h283, 10'h17C), 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0, 1'b1};
        vecs[10] = '{w4(10'h283, 10'h155, 10'h155, 10'h155), 32'hB5B5B5BC, 4'h1, 4'h0, 4'h0, 1'b0};
        vecs[11] = '{w4(10'h07C, 10'h1DC, 10'h383, 10'h3A8), 32'hF7FCFCFC, 4'hD, 4'h0, 4'h0, 1'b1};
        vecs[12] = '{w4(10'h21C, 10'h057, 10'h39C, 10'h071), 32'hF1FCF7FC, 4'h2, 4'hC, 4'h0, 1'b0};
        vecs[13] = '{w4(10'h23C, 10'h1F1, 10'h3B1, 10'h155), 32'hB5F1F1FC, 4'h0, 4'h3, 4'h4, 1'b1};
        vecs[14] = '{w4(10'h0FF, 10'h155, 10'h155, 10'h155), 32'hB5B5B560, 4'h0, 4'h1, 4'h1, 1'b0};
        vecs[15] = '{w4(10'h17C, 10'h283, 10'h17C, 10'h283), 32'hBCBCBCBC, 4'hF, 4'h0, 4'h0, 1'b0};

        reset   = 1'b1;
        in_data = '0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 16; i++) step(vecs[i], i);

        // Mid-stream asynchronous reset
        step(vecs[0], 100);
        step(vecs[0], 101);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero("reset_async");
        sb.delete();
        @(posedge clk);
        #2;
        check_zero("reset_held");
        reset   = 1'b0;
        in_data = vecs[0].din;
        push(cyc,     200, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(cyc + 1, 201, 32'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        push(cyc + 2, 202, vecs[0].data, vecs[0].k, vecs[0].nit, vecs[0].de, vecs[0].rd);
        @(negedge clk);
        check_due();
        step(vecs[0], 203);
        step(vecs[2], 204);
        step(vecs[4], 205);

        repeat (4) begin
            @(negedge clk);
            check_due();
        end
        tests++;
        if (sb.size() != 0) begin
            failed += sb.size();
            $display("[TB] FAIL drain got %0d pending words exp 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
